pmem_line_responder: RTL and testbench
======================================

// Module: pmem_line_responder
// PURPOSE
// - Physical-memory responder on the cache's 256-bit line interface (pmem_*).
// - Serves whole-line reads/writes from an internal line store after a programmable latency.
// - Sits below the 2-way cache as its pmem target in block-level benches and small FPGA builds.
// PARAMETERS
// - LATENCY    4   cycles from request accept to pmem_resp (legal range 1..255)
// - IDX_W      6   line-index width; store holds 2**IDX_W lines of 256 bits
// PORTS
// - clk             in   1    clock; all logic on rising edge
// - rst             in   1    reset; synchronous, active-high
// - pmem_read       in   1    line read request; held by cache until pmem_resp
// - pmem_write      in   1    line write request; held by cache until pmem_resp
// - pmem_address    in   32   line address; [4:0] ignored, index = [IDX_W+4:5], upper bits ignored
// - pmem_wdata      in   256  write line data
// - pmem_rdata      out  256  read line data; valid in the pmem_resp cycle of a read
// - pmem_resp       out  1    one-cycle completion pulse
// - busy            out  1    high from accept until pmem_resp cycle inclusive
// - rd_count        out  32   completed reads (PMEM_STATS_EN only)
// - wr_count        out  32   completed writes (PMEM_STATS_EN only)
// BEHAVIOUR
// - Reset values: pmem_resp=0, busy=0, pmem_rdata=0, rd_count=0, wr_count=0, state=IDLE.
// - Reset clears per-line valid bits; reading a never-written line returns 256'h0.
// - Line data array is not reset.
// - FSM IDLE: on (pmem_read|pmem_write), capture op, index and wdata; load cnt=LATENCY-1.
//   Go to BUSY if cnt!=0, else go to RESP.
// - FSM BUSY: cnt decrements each cycle; when cnt==1, go to RESP.
// - FSM RESP: pmem_resp=1 for exactly this cycle, then return to IDLE.
// - Latency: request first seen high in IDLE at cycle 0 -> pmem_resp high in cycle LATENCY.
// - Read: pmem_rdata loads from the captured index on the edge entering RESP.
//   pmem_rdata holds its value until the next read completes; writes do not change it.
// - Write: captured wdata goes to the array and the line's valid bit is set on the edge leaving RESP.
//   A read issued next returns the new data.
// - Read and write both high at accept: treated as a write; the read is dropped.
// - Inputs are sampled only at accept. Changes to address, data or op during BUSY/RESP are ignored.
// - Request deasserted mid-operation: the operation still completes and pmem_resp still pulses.
// - The cache drops its request on the edge after pmem_resp, so IDLE can accept the next request
//   in the cycle right after RESP. No dead cycle is required.
// - rst during BUSY/RESP: go to IDLE, no pmem_resp, the captured write is discarded,
//   and valid bits are cleared.
// CONFIGURATION
// - PMEM_STATS_EN defined:
//   - rd_count increments on each read RESP cycle; wr_count increments on each write RESP cycle.
//   - Both counters are 32-bit and wrap from 32'hFFFF_FFFF to 0.
// - PMEM_STATS_EN undefined: rd_count/wr_count tied to 32'h0 and no counter flops exist.
// TESTING
// - Reset, LATENCY=4; read addr 32'h0000_0040 at cycle 0 -> resp in cycle 4 only,
//   pmem_rdata=256'h0, busy high cycles 0..4.
// - Write addr 32'h0000_0060, wdata={8{32'hDEAD_BEEF}} -> resp at +4.
//   Back-to-back read of 32'h0000_0067 -> rdata={8{32'hDEAD_BEEF}}.
// - Write index 2, then read addr 32'h0000_0840 (index 2 when IDX_W=6, tag differs)
//   -> same line returned, because upper address bits are ignored.
// - read=write=1 at accept with wdata=256'h1 -> treated as write; subsequent read returns 256'h1.
//   pmem_rdata is unchanged by the combined access.
// - Assert rst in cycle 2 of a write -> no resp; the line later reads 256'h0. busy=0 the cycle after rst.
// - LATENCY=1, PMEM_STATS_EN on: 3 reads + 2 writes back-to-back -> each resp 1 cycle after accept;
//   rd_count=3, wr_count=2.

Source files
------------

// File: rtl/pmem_line_responder_if.sv
// 256-bit line bus between the cache (master) and the pmem line responder (slave).
interface pmem_line_responder_if;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic         busy;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp, busy
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp, busy
    );
endinterface

// File: rtl/pmem_line_responder.sv
// Whole-line physical-memory responder with a fixed, programmable response latency.
// Define PMEM_STATS_EN to build the completed read/write counters; otherwise they read as zero.
module pmem_line_responder #(
    parameter int LATENCY = 4,
    parameter int IDX_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    pmem_line_responder_if.slave  bus,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
    localparam int         LINES    = 1 << IDX_W;

    logic [1:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             is_write_q, is_write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [255:0]     wdata_q, wdata_d;
    logic [255:0]     rdata_q, rdata_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [255:0]     mem_q [LINES];

    logic             req;
    logic             mem_we;
    logic [IDX_W-1:0] req_idx;
    logic             unused_addr;

    assign req         = bus.pmem_read | bus.pmem_write;
    assign req_idx     = bus.pmem_address[IDX_W+4:5];
    assign unused_addr = ^{bus.pmem_address[31:IDX_W+5], bus.pmem_address[4:0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    is_write_d = bus.pmem_write;
                    idx_d      = req_idx;
                    wdata_d    = bus.pmem_wdata;
                    cnt_d      = CNT_INIT;
                    state_d    = (CNT_INIT != 8'd0) ? ST_BUSY : ST_RESP;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // idx_d/is_write_d already reflect a same-cycle accept, so LATENCY=1 reads the right line.
    always_comb begin
        rdata_d = rdata_q;
        valid_d = valid_q;
        mem_we  = (state_q == ST_RESP) && is_write_q;
        if ((state_d == ST_RESP) && !is_write_d) begin
            rdata_d = valid_q[idx_d] ? mem_q[idx_d] : 256'h0;
        end
        if (mem_we) begin
            valid_d[idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.pmem_rdata = rdata_q;
    assign bus.pmem_resp  = (state_q == ST_RESP);
    assign bus.busy       = !rst && ((state_q != ST_IDLE) || req);

`ifdef PMEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (state_q == ST_RESP) begin
            if (is_write_q) begin
                wr_count_d = wr_count_q + 32'd1;
            end else begin
                rd_count_d = rd_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = 32'h0;
    assign wr_count = 32'h0;
`endif

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench: a LATENCY=4 instance driven from a vector table plus corner sequences,
// and a LATENCY=1 instance for back-to-back traffic and the optional counters.
module tb_pmem_line_responder;

    localparam logic [255:0] DEAD = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] PAT1 = {8{32'h1234_5678}};
    localparam logic [255:0] PATA = {8{32'hA5A5_5A5A}};
    localparam logic [255:0] PATC = {8{32'hC0FF_EE00}};
    localparam logic [255:0] PATE = {8{32'h0BAD_F00D}};
    localparam logic [255:0] PATW1 = {8{32'h1111_2222}};
    localparam logic [255:0] PATW2 = {8{32'h3333_4444}};

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
        logic [255:0] expRdata;
    } vec_t;

    logic clk;
    logic rst;
    logic [31:0] rdCountA, wrCountA, rdCountB, wrCountB;
    int checks;
    int errors;
    vec_t vecs[12];
    logic [255:0] rdOut;
    logic [7:0] busyMask;
    int respCount;

    pmem_line_responder_if ifA ();
    pmem_line_responder_if ifB ();

    pmem_line_responder #(.LATENCY(4), .IDX_W(6)) dutA (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifA),
        .rd_count (rdCountA),
        .wr_count (wrCountA)
    );

    pmem_line_responder #(.LATENCY(1), .IDX_W(6)) dutB (
        .clk      (clk),
        .rst      (rst),
        .bus      (ifB),
        .rd_count (rdCountB),
        .wr_count (wrCountB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic setReq(input bit useB, input bit rd, input bit wr, input logic [31:0] addr, input logic [255:0] wd);
        if (useB) begin
            ifB.pmem_read    = rd;
            ifB.pmem_write   = wr;
            ifB.pmem_address = addr;
            ifB.pmem_wdata   = wd;
        end else begin
            ifA.pmem_read    = rd;
            ifA.pmem_write   = wr;
            ifA.pmem_address = addr;
            ifA.pmem_wdata   = wd;
        end
    endtask

    // Called just after a rising edge; returns just after the edge following the response cycle.
    task automatic applyStimulus(input bit useB, input bit rd, input bit wr, input logic [31:0] addr,
                                 input logic [255:0] wd, input int expLat, input int dropAt,
                                 input string tag, output logic [255:0] rdataAtResp, output logic [7:0] mask);
        bit seen;
        int lat;
        seen = 1'b0;
        lat = -1;
        mask = '0;
        rdataAtResp = '0;
        setReq(useB, rd, wr, addr, wd);
        for (int c = 0; c <= expLat + 3 && !seen; c++) begin
            if (c == dropAt) setReq(useB, 1'b0, 1'b0, addr ^ 32'hFFFF_FFE0, ~wd);
            @(negedge clk);
            if (c < 8) mask[3'(c)] = useB ? ifB.busy : ifA.busy;
            if (useB ? ifB.pmem_resp : ifA.pmem_resp) begin
                seen = 1'b1;
                lat = c;
                rdataAtResp = useB ? ifB.pmem_rdata : ifA.pmem_rdata;
            end
            @(posedge clk);
            #1;
        end
        setReq(useB, 1'b0, 1'b0, 32'h0, 256'h0);
        checkOutput({tag, " latency"}, 256'(lat), 256'(expLat));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0]  = '{1'b1, 1'b0, 32'h0000_0040, 256'h0, 256'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0000_0060, DEAD,   256'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0067, 256'h0, DEAD};
        vecs[3]  = '{1'b0, 1'b1, 32'h0000_0040, PAT1,   DEAD};
        vecs[4]  = '{1'b1, 1'b0, 32'h0000_0840, 256'h0, PAT1};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_F85F, 256'h0, PAT1};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_00A0, 256'h1, PAT1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_00A0, 256'h0, 256'h1};
        vecs[8]  = '{1'b1, 1'b0, 32'h0000_07E0, 256'h0, 256'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h0000_07E0, PATA,   256'h0};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_07FF, 256'h0, PATA};
        vecs[11] = '{1'b1, 1'b0, 32'h0800_07E0, 256'h0, PATA};

        rst = 1'b1;
        setReq(1'b0, 1'b0, 1'b0, 32'h0, 256'h0);
        setReq(1'b1, 1'b0, 1'b0, 32'h0, 256'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset resp", 256'(ifA.pmem_resp), 256'h0);
        checkOutput("reset busy", 256'(ifA.busy), 256'h0);
        checkOutput("reset rdata", ifA.pmem_rdata, 256'h0);
        checkOutput("reset rd_count", 256'(rdCountB), 256'h0);
        checkOutput("reset wr_count", 256'(wrCountB), 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] first read of an unwritten line");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0040, 256'h0, 4, -1, "s1 read", rdOut, busyMask);
        checkOutput("s1 rdata", rdOut, 256'h0);
        checkOutput("s1 busy window", 256'(busyMask), 256'h1F);
        @(negedge clk);
        checkOutput("s1 resp after", 256'(ifA.pmem_resp), 256'h0);
        checkOutput("s1 busy after", 256'(ifA.busy), 256'h0);
        @(posedge clk);
        #1;

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 4, -1,
                          $sformatf("vec%0d", i), rdOut, busyMask);
            checkOutput($sformatf("vec%0d rdata", i), rdOut, vecs[i].expRdata);
        end

        $display("[TB] request dropped and inputs scribbled mid-operation");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_00C0, PATC, 4, 1, "s2 write", rdOut, busyMask);
        checkOutput("s2 busy window", 256'(busyMask), 256'h1F);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_00C0, 256'h0, 4, -1, "s2 read back", rdOut, busyMask);
        checkOutput("s2 captured line", rdOut, PATC);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'hFFFF_FF20, 256'h0, 4, -1, "s2 read scribble", rdOut, busyMask);
        checkOutput("s2 scribbled line", rdOut, 256'h0);

        $display("[TB] reset in cycle 2 of a write");
        setReq(1'b0, 1'b0, 1'b1, 32'h0000_00E0, PATE);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        setReq(1'b0, 1'b0, 1'b0, 32'h0, 256'h0);
        @(negedge clk);
        checkOutput("s3 resp in rst", 256'(ifA.pmem_resp), 256'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("s3 busy after rst", 256'(ifA.busy), 256'h0);
        checkOutput("s3 rdata after rst", ifA.pmem_rdata, 256'h0);
        respCount = 0;
        for (int c = 0; c < 6; c++) begin
            if (ifA.pmem_resp) respCount++;
            @(negedge clk);
        end
        checkOutput("s3 no resp", 256'(respCount), 256'h0);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_00E0, 256'h0, 4, -1, "s3 read aborted", rdOut, busyMask);
        checkOutput("s3 aborted line", rdOut, 256'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0000_0060, 256'h0, 4, -1, "s3 read cleared", rdOut, busyMask);
        checkOutput("s3 valid cleared", rdOut, 256'h0);

        $display("[TB] LATENCY=1 back-to-back traffic");
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0020, PATW1, 1, -1, "s4 w1", rdOut, busyMask);
        checkOutput("s4 w1 busy window", 256'(busyMask), 256'h03);
        checkOutput("s4 w1 rdata", rdOut, 256'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0020, 256'h0, 1, -1, "s4 r1", rdOut, busyMask);
        checkOutput("s4 r1 rdata", rdOut, PATW1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0040, PATW2, 1, -1, "s4 w2", rdOut, busyMask);
        checkOutput("s4 w2 rdata", rdOut, PATW1);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0040, 256'h0, 1, -1, "s4 r2", rdOut, busyMask);
        checkOutput("s4 r2 rdata", rdOut, PATW2);
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0000_0060, 256'h0, 1, -1, "s4 r3", rdOut, busyMask);
        checkOutput("s4 r3 rdata", rdOut, 256'h0);
        @(negedge clk);
`ifdef PMEM_STATS_EN
        checkOutput("s4 rd_count", 256'(rdCountB), 256'd3);
        checkOutput("s4 wr_count", 256'(wrCountB), 256'd2);
`else
        checkOutput("s4 rd_count tied", 256'(rdCountB), 256'd0);
        checkOutput("s4 wr_count tied", 256'(wrCountB), 256'd0);
        checkOutput("A rd_count tied", 256'(rdCountA), 256'd0);
        checkOutput("A wr_count tied", 256'(wrCountA), 256'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
